// File: rtl/imem_loader.sv
// Loads a framed program image from a byte stream into instruction RAM,
// holding the CPU in reset while the image is being written.
module imem_loader #(
    parameter int ADDR_BITS      = 10,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 imem_we,
    output logic [ADDR_BITS-1:0] imem_addr,
    output logic [DATA_BITS-1:0] imem_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_BITS:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERROR
    } state_t;

    localparam int             TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int             TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_LAST_INT);
    localparam logic [16:0]    MAX_LEN = 17'(1) << ADDR_BITS;
    localparam logic [7:0]     SYNC    = 8'hA5;

    state_t               state_reg;
    logic [7:0]           len_hi_reg;
    logic [15:0]          len_reg;
    logic [7:0]           chk_reg;
    logic [1:0]           byte_idx_reg;
    logic [DATA_BITS-1:0] word_reg;
    logic [TO_BITS-1:0]   to_cnt_reg;

    logic                 accept;
    logic [15:0]          len_rx;
    logic [DATA_BITS-1:0] word_shifted;
    logic [ADDR_BITS:0]   wl_inc;
    logic                 timed_out;
    logic                 in_timed_state;

    assign accept         = rx_valid && rx_ready;
    assign len_rx         = {len_hi_reg, rx_data};
    assign word_shifted   = {word_reg[DATA_BITS-9:0], rx_data};
    assign wl_inc         = words_loaded + 1'b1;
    assign timed_out      = TO_EN && (to_cnt_reg == TO_LAST);
    assign in_timed_state = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                            (state_reg == DATA)   || (state_reg == CHK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_hi_reg   <= '0;
            len_reg      <= '0;
            chk_reg      <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            to_cnt_reg   <= '0;
            rx_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;

            // Idle-gap watchdog; an accepted byte always takes priority over expiry.
            if (in_timed_state) begin
                if (accept) begin
                    to_cnt_reg <= '0;
                end else if (timed_out) begin
                    state_reg <= ERROR;
                    error     <= 1'b1;
                    busy      <= 1'b0;
                end else if (TO_EN) begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (accept && rx_data == SYNC) begin
                        state_reg    <= LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        chk_reg      <= '0;
                        imem_addr    <= '0;
                        byte_idx_reg <= '0;
                        to_cnt_reg   <= '0;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi_reg <= rx_data;
                        state_reg  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_reg <= len_rx;
                        if ({1'b0, len_rx} > MAX_LEN) begin
                            state_reg <= ERROR;
                            error     <= 1'b1;
                            busy      <= 1'b0;
                        end else if (len_rx == 16'd0) begin
                            state_reg <= CHK;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_reg     <= word_shifted;
                        chk_reg      <= chk_reg + rx_data;
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg  <= WRITE;
                            imem_we    <= 1'b1;
                            imem_wdata <= word_shifted;
                            rx_ready   <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    // imem_addr is ADDR_BITS wide, so a full-depth image wraps it to 0.
                    imem_addr    <= imem_addr + 1'b1;
                    words_loaded <= wl_inc;
                    rx_ready     <= 1'b1;
                    to_cnt_reg   <= '0;
                    if (17'(wl_inc) == {1'b0, len_reg}) begin
                        state_reg <= CHK;
                    end else begin
                        state_reg <= DATA;
                    end
                end
                CHK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (rx_data == chk_reg) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state_reg <= ERROR;
                            error     <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frame tests for imem_loader against a frame-level
// model: expected writes are the frame words at consecutive addresses.
module tb_imem_loader;

    localparam int AB    = 10;
    localparam int TO    = 16;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AB-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [AB:0]   words_loaded;

    imem_loader #(
        .ADDR_BITS(AB),
        .DATA_BITS(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rdy_low_cnt = 0;
    int          we_rdy_low_cnt = 0;
    logic [31:0] frame_words[$];

    // Observe write port and ready just after each edge.
    always @(posedge clk) begin
        #1;
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        if (!rx_ready) rdy_low_cnt++;
        if (imem_we && !rx_ready) we_rdy_low_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rdy_low_cnt    = 0;
        we_rdy_low_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit rd;
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (1) begin
            rd = rx_ready;
            @(negedge clk);
            if (rd) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_byte_stall observed=rx_ready_low expected=accept_within_50");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends frame_words as a frame; chk_off=0 gives the correct checksum.
    task automatic send_frame(input int chk_off, input int gap_max);
        int sum;
        int len;
        logic [7:0] b;
        sum = 0;
        len = frame_words.size();
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'((len >> 8) & 255));
        send_byte(8'(len & 255));
        foreach (frame_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b   = 8'((frame_words[i] >> (24 - 8 * k)) & 32'hFF);
                sum = sum + int'(b);
                send_byte(b);
                if (gap_max > 0 && $urandom_range(0, 3) == 0)
                    idle($urandom_range(1, gap_max));
            end
        end
        send_byte(8'((sum + chk_off) & 255));
        rx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input bit good);
        int mism;
        int n;
        idle(3);
        chk({tag, "_nwr"}, 64'(wr_data_q.size()), 64'(frame_words.size()));
        mism = 0;
        n = (wr_data_q.size() < frame_words.size()) ? wr_data_q.size() : frame_words.size();
        for (int i = 0; i < n; i++) begin
            if (wr_data_q[i] !== frame_words[i] || wr_addr_q[i] != (i % DEPTH)) mism++;
        end
        chk({tag, "_wr_mismatches"}, 64'(mism), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'(good));
        chk({tag, "_error"}, 64'(error), 64'(!good));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!good));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(frame_words.size()));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
        chk({tag, "_ready"}, 64'(rx_ready), 64'd1);
    endtask

    initial begin
        int off;
        int sum;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single word, checksum 0x14
        frame_words = '{32'h12345678};
        send_frame(0, 0);
        check_frame("single", 1'b1);
        if (wr_data_q.size() > 0) begin
            chk("single_data", 64'(wr_data_q[0]), 64'h12345678);
            chk("single_addr", 64'(wr_addr_q[0]), 64'd0);
        end

        // Three words back-to-back; ready low only in the write cycles
        frame_words = '{$urandom(), $urandom(), $urandom()};
        send_frame(0, 0);
        check_frame("three", 1'b1);
        chk("three_rdy_low", 64'(rdy_low_cnt), 64'd3);
        chk("three_we_rdy_low", 64'(we_rdy_low_cnt), 64'd3);

        // Bad checksum (0x15), then recovery
        frame_words = '{32'h12345678};
        send_frame(1, 0);
        check_frame("badchk", 1'b0);
        frame_words = '{$urandom(), $urandom()};
        send_frame(0, 0);
        check_frame("recover", 1'b1);

        // Oversize length 1025
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        rx_valid = 1'b0;
        chk("oversize_error", 64'(error), 64'd1);
        chk("oversize_hold", 64'(cpu_hold), 64'd1);
        chk("oversize_busy", 64'(busy), 64'd0);
        idle(3);
        chk("oversize_nwr", 64'(wr_data_q.size()), 64'd0);
        frame_words.delete();
        send_frame(0, 0);
        check_frame("zerolen", 1'b1);

        // Timeout: error exactly TO cycles after last accept
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        rx_valid = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("timeout_early", 64'(error), 64'd0);
        @(negedge clk);
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_hold", 64'(cpu_hold), 64'd1);
        chk("timeout_nwr", 64'(wr_data_q.size()), 64'd0);

        // Reset in the middle of DATA, then garbage in IDLE
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 8'hA4)));
        idle(3);
        check_reset("garbage");
        chk("garbage_nwr", 64'(wr_data_q.size()), 64'd0);

        // Randomized frames with gaps and random checksum correctness
        for (int f = 0; f < 8; f++) begin
            frame_words.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) frame_words.push_back($urandom());
            off = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : 0;
            send_frame(off, 10);
            check_frame($sformatf("rand%0d", f), off == 0);
        end

        // Full-depth image: address wraps to 0 without an extra write
        frame_words.delete();
        for (int i = 0; i < DEPTH; i++) frame_words.push_back($urandom());
        send_frame(0, 0);
        check_frame("full", 1'b1);
        chk("full_addr_wrap", 64'(imem_addr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
